csr_unit: RTL and testbench

Parametrised machine-mode control/status register unit for the riskproc core. It services single-cycle CSR read/modify/write requests from the execute stage and performs trap entry and `mret` state updates. It also maintains 64-bit cycle, instret, timer and optional hardware-performance counters, and produces the interrupt-pending signals consumed by the fetch/trap logic.

---
 rtl/csr_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_csr_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR block for the riskproc core.
//
// Services single-cycle CSR read/modify/write requests, performs trap entry
// and mret updates to mstatus/mepc/mcause/mtval, and keeps the 64-bit
// mcycle/minstret/mtime counters, mtimecmp and optional mhpmcounters.
//
// Optional feature macro: CSR_HPM_EN. When defined, NUM_HPM mhpmcounter
// channels (3..NUM_HPM+2) are built. When undefined, those addresses still
// decode as legal, read 0 and ignore writes, and hpm_event is unused.
//
// Ports:
//   clk, resetn             core clock, asynchronous active-low reset
//   csr_req/op/addr/wdata   CSR access (op: 0 RO, 1 RW, 2 RS, 3 RC)
//   csr_rdata, csr_illegal  old CSR value and reject flag (combinational)
//   retire, hpm_event       counter event strobes
//   trap_valid/cause/pc/tval  trap entry
//   mret                    return from trap
//   ext_irq, sw_irq         level-sensitive MEIP / MSIP
//   mtvec, mepc             trap vector and return PC
//   irq_pending             enabled interrupt pending with mstatus.MIE set

// 64-bit counter with per-half write; a write wins over the increment.
module csr_cnt64 (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] cnt
);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)    cnt         <= '0;
        else if (wr_lo) cnt[31:0]  <= wdata;
        else if (wr_hi) cnt[63:32] <= wdata;
        else if (inc)   cnt         <= cnt + 64'd1;
    end
endmodule

module csr_unit #(
    parameter int          XLEN        = 32,
    parameter int          NUM_HPM     = 4,
    parameter logic [31:0] MTVEC_RESET = 32'h0,
    parameter logic [31:0] HART_ID     = 32'h0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               csr_req,
    input  logic [1:0]         csr_op,
    input  logic [11:0]        csr_addr,
    input  logic [XLEN-1:0]    csr_wdata,
    output logic [XLEN-1:0]    csr_rdata,
    output logic               csr_illegal,
    input  logic               retire,
    input  logic [NUM_HPM-1:0] hpm_event,
    input  logic               trap_valid,
    input  logic [XLEN-1:0]    trap_cause,
    input  logic [XLEN-1:0]    trap_pc,
    input  logic [XLEN-1:0]    trap_tval,
    input  logic               mret,
    input  logic               ext_irq,
    input  logic               sw_irq,
    output logic [XLEN-1:0]    mtvec,
    output logic [XLEN-1:0]    mepc,
    output logic               irq_pending
);
    localparam logic [63:0] HPM_BITS = ((64'd1 << NUM_HPM) - 64'd1) << 3;
`ifdef CSR_HPM_EN
    localparam logic [31:0] INH_MASK = 32'h5 | HPM_BITS[31:0];
`else
    localparam logic [31:0] INH_MASK = 32'h5;
`endif
    localparam logic [31:0] MIE_MASK = 32'h0000_0888;

    logic        st_mie, st_mpie, mtip_q;
    logic [31:0] mie_q, mtvec_q, minh_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [63:0] mtimecmp_q, mcycle_cnt, minstret_cnt, mtime_cnt;
    logic [NUM_HPM-1:0][63:0] hpm_cnt;
    logic [31:0] rd_val, wval, mip;
    logic        rd_ok, wr_req, do_wr;

    assign mip = {20'b0, ext_irq, 3'b0, mtip_q, 3'b0, sw_irq, 3'b0};

    // Read mux; rd_ok flags an implemented address.
    always_comb begin
        rd_val = '0;
        rd_ok  = 1'b1;
        case (csr_addr)
            12'h300: rd_val = {24'b0, st_mpie, 3'b0, st_mie, 3'b0};
            12'h301: rd_val = 32'h4000_0100;
            12'h304: rd_val = mie_q;
            12'h305: rd_val = mtvec_q;
            12'h320: rd_val = minh_q;
            12'h340: rd_val = mscratch_q;
            12'h341: rd_val = mepc_q;
            12'h342: rd_val = mcause_q;
            12'h343: rd_val = mtval_q;
            12'h344: rd_val = mip;
            12'h7C0: rd_val = mtimecmp_q[31:0];
            12'h7C1: rd_val = mtimecmp_q[63:32];
            12'hB00: rd_val = mcycle_cnt[31:0];
            12'hB80: rd_val = mcycle_cnt[63:32];
            12'hB02: rd_val = minstret_cnt[31:0];
            12'hB82: rd_val = minstret_cnt[63:32];
            12'hF11, 12'hF12, 12'hF13: rd_val = '0;
            12'hF14: rd_val = HART_ID;
            12'hFC0: rd_val = mtime_cnt[31:0];
            12'hFC1: rd_val = mtime_cnt[63:32];
            default: begin
                rd_ok = 1'b0;
                for (int i = 0; i < NUM_HPM; i++) begin
                    if (csr_addr == 12'(12'hB03 + i)) begin
                        rd_val = hpm_cnt[i][31:0];
                        rd_ok  = 1'b1;
                    end
                    if (csr_addr == 12'(12'hB83 + i)) begin
                        rd_val = hpm_cnt[i][63:32];
                        rd_ok  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        case (csr_op)
            2'd2:    wval = rd_val | csr_wdata;
            2'd3:    wval = rd_val & ~csr_wdata;
            default: wval = csr_wdata;
        endcase
    end

    // RS/RC with a zero operand is a pure read and may target read-only space.
    assign wr_req      = (csr_op == 2'd1) || (csr_op[1] && |csr_wdata);
    assign csr_illegal = csr_req && (!rd_ok || (wr_req && csr_addr[11:10] == 2'b11));
    assign do_wr       = csr_req && wr_req && !csr_illegal;
    assign csr_rdata   = csr_req ? rd_val : '0;

    assign mtvec       = mtvec_q;
    assign mepc        = mepc_q;
    assign irq_pending = st_mie && |(mip & mie_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            mtip_q     <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RESET & ~32'h2;
            minh_q     <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mtimecmp_q <= '1;
        end else begin
            mtip_q <= (mtime_cnt >= mtimecmp_q);
            // trap > mret > CSR write for the registers they share
            if (trap_valid) begin
                st_mpie <= st_mie;
                st_mie  <= 1'b0;
            end else if (mret) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end else if (do_wr && csr_addr == 12'h300) begin
                st_mie  <= wval[3];
                st_mpie <= wval[7];
            end
            if (trap_valid) begin
                mepc_q   <= {trap_pc[31:2], 2'b00};
                mcause_q <= trap_cause;
                mtval_q  <= trap_tval;
            end else if (do_wr) begin
                if (csr_addr == 12'h341) mepc_q   <= {wval[31:2], 2'b00};
                if (csr_addr == 12'h342) mcause_q <= wval;
                if (csr_addr == 12'h343) mtval_q  <= wval;
            end
            if (do_wr) begin
                case (csr_addr)
                    12'h304: mie_q             <= wval & MIE_MASK;
                    12'h305: mtvec_q           <= wval & ~32'h2;
                    12'h320: minh_q            <= wval & INH_MASK;
                    12'h340: mscratch_q        <= wval;
                    12'h7C0: mtimecmp_q[31:0]  <= wval;
                    12'h7C1: mtimecmp_q[63:32] <= wval;
                    default: ;
                endcase
            end
        end
    end

    csr_cnt64 u_mcycle (
        .clk(clk), .resetn(resetn), .inc(!minh_q[0]),
        .wr_lo(do_wr && csr_addr == 12'hB00), .wr_hi(do_wr && csr_addr == 12'hB80),
        .wdata(wval), .cnt(mcycle_cnt));

    csr_cnt64 u_minstret (
        .clk(clk), .resetn(resetn), .inc(retire && !minh_q[2]),
        .wr_lo(do_wr && csr_addr == 12'hB02), .wr_hi(do_wr && csr_addr == 12'hB82),
        .wdata(wval), .cnt(minstret_cnt));

    csr_cnt64 u_mtime (
        .clk(clk), .resetn(resetn), .inc(1'b1),
        .wr_lo(1'b0), .wr_hi(1'b0),
        .wdata(wval), .cnt(mtime_cnt));

`ifdef CSR_HPM_EN
    for (genvar i = 0; i < NUM_HPM; i++) begin : g_hpm
        csr_cnt64 u_hpm (
            .clk(clk), .resetn(resetn), .inc(hpm_event[i] && !minh_q[i+3]),
            .wr_lo(do_wr && csr_addr == 12'(12'hB03 + i)),
            .wr_hi(do_wr && csr_addr == 12'(12'hB83 + i)),
            .wdata(wval), .cnt(hpm_cnt[i]));
    end
    logic unused_bits;
    assign unused_bits = ^trap_pc[1:0];
`else
    assign hpm_cnt = '0;
    logic unused_bits;
    assign unused_bits = ^{trap_pc[1:0], hpm_event};
`endif
endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit (default parameters except
// MTVEC_RESET/HART_ID so their reset/read paths are visible).
module tb_csr_unit;
    localparam logic [31:0] MTVEC_RST = 32'h0000_0100;
    localparam logic [31:0] HART      = 32'h0000_0005;
    localparam int          NH        = 4;

    logic          clk = 1'b0, resetn = 1'b0;
    logic          csr_req = 1'b0;
    logic [1:0]    csr_op = '0;
    logic [11:0]   csr_addr = '0;
    logic [31:0]   csr_wdata = '0;
    logic [31:0]   csr_rdata;
    logic          csr_illegal;
    logic          retire = 1'b0;
    logic [NH-1:0] hpm_event = '0;
    logic          trap_valid = 1'b0;
    logic [31:0]   trap_cause = '0, trap_pc = '0, trap_tval = '0;
    logic          mret = 1'b0, ext_irq = 1'b0, sw_irq = 1'b0;
    logic [31:0]   mtvec, mepc;
    logic          irq_pending;

    int errors = 0, checks = 0;
    logic [31:0] r, m, hpm_exp, inh_exp;
    logic        il;

    csr_unit #(.XLEN(32), .NUM_HPM(NH), .MTVEC_RESET(MTVEC_RST), .HART_ID(HART)) dut (
        .clk(clk), .resetn(resetn), .csr_req(csr_req), .csr_op(csr_op),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .csr_illegal(csr_illegal), .retire(retire), .hpm_event(hpm_event),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .trap_tval(trap_tval), .mret(mret), .ext_irq(ext_irq), .sw_irq(sw_irq),
        .mtvec(mtvec), .mepc(mepc), .irq_pending(irq_pending));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // One CSR access: sample combinational outputs mid-cycle, then commit.
    task automatic acc(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic ill);
        csr_req = 1'b1; csr_op = op; csr_addr = a; csr_wdata = wd;
        #1;
        rd = csr_rdata; ill = csr_illegal;
        step();
        csr_req = 1'b0; csr_op = '0; csr_wdata = '0;
    endtask

    task automatic rdc(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] v; logic i;
        acc(2'd0, a, 32'h0, v, i);
        chk(tag, v, exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        logic [31:0] v; logic i;
        acc(2'd1, a, d, v, i);
    endtask

    initial begin
`ifdef CSR_HPM_EN
        hpm_exp = 32'd7;  inh_exp = 32'h7D;
`else
        hpm_exp = 32'd0;  inh_exp = 32'h05;
`endif
        repeat (2) step();
        chk("rst_mtvec_port", mtvec, MTVEC_RST);
        chk("rst_mepc_port", mepc, 32'h0);
        chk("rst_irq", {31'b0, irq_pending}, 32'h0);
        resetn = 1'b1;
        step();

        rdc("rst_mtvec_csr", 12'h305, MTVEC_RST);
        rdc("rst_cmp_lo", 12'h7C0, 32'hFFFF_FFFF);
        rdc("rst_cmp_hi", 12'h7C1, 32'hFFFF_FFFF);
        rdc("misa", 12'h301, 32'h4000_0100);
        rdc("mhartid", 12'hF14, HART);

        // RW / RS / RC on mscratch
        wr(12'h340, 32'h0000_F0F0);
        acc(2'd2, 12'h340, 32'h0000_0F00, r, il);
        chk("rs_old", r, 32'h0000_F0F0);
        rdc("rs_new", 12'h340, 32'h0000_FFF0);
        acc(2'd3, 12'h340, 32'h0000_00F0, r, il);
        rdc("rc_new", 12'h340, 32'h0000_FF00);
        acc(2'd2, 12'h340, 32'h0, r, il);
        rdc("rs_zero_nowrite", 12'h340, 32'h0000_FF00);

        // illegal accesses
        acc(2'd1, 12'hF14, 32'h1234, r, il);
        chk("wr_hartid_ill", {31'b0, il}, 32'h1);
        acc(2'd2, 12'hF14, 32'h0, r, il);
        chk("rs0_hartid_legal", {31'b0, il}, 32'h0);
        chk("hartid_unchanged", r, HART);
        acc(2'd0, 12'h123, 32'h0, r, il);
        chk("unimpl_ill", {31'b0, il}, 32'h1);
        acc(2'd1, 12'hFC0, 32'h0, r, il);
        chk("wr_mtime_ill", {31'b0, il}, 32'h1);
        acc(2'd0, 12'hB07, 32'h0, r, il);
        chk("hpm_oob_ill", {31'b0, il}, 32'h1);

        // mip and mtvec masking
        sw_irq = 1'b1; ext_irq = 1'b1;
        rdc("mip_sw_ext", 12'h344, 32'h0000_0808);
        chk("irq_mie0", {31'b0, irq_pending}, 32'h0);
        sw_irq = 1'b0; ext_irq = 1'b0;
        wr(12'h305, 32'h0000_2003);
        chk("mtvec_bit1", mtvec, 32'h0000_2001);

        // trap entry with an unrelated CSR write in the same cycle
        wr(12'h300, 32'h0000_0008);
        rdc("mstatus_mie", 12'h300, 32'h0000_0008);
        trap_valid = 1'b1; trap_pc = 32'h0000_1003;
        trap_cause = 32'h8000_000B; trap_tval = 32'h0000_DEAD;
        wr(12'h340, 32'h0000_1234);
        trap_valid = 1'b0;
        chk("trap_mepc", mepc, 32'h0000_1000);
        mret = 1'b1;
        rdc("trap_mstatus", 12'h300, 32'h0000_0080);
        mret = 1'b0;
        rdc("mret_mstatus", 12'h300, 32'h0000_0088);
        rdc("trap_mcause", 12'h342, 32'h8000_000B);
        rdc("trap_mtval", 12'h343, 32'h0000_DEAD);
        rdc("trap_side_write", 12'h340, 32'h0000_1234);

        // counter write suppresses increment, then wrap
        wr(12'hB00, 32'h0000_0010);
        rdc("mcycle_wr", 12'hB00, 32'h0000_0010);
        wr(12'hB00, 32'hFFFF_FFFF);
        wr(12'hB80, 32'hFFFF_FFFF);
        step();
        rdc("wrap_lo", 12'hB00, 32'h0);
        rdc("wrap_hi", 12'hB80, 32'h0);

        // minstret inhibit
        rdc("minstret0", 12'hB02, 32'h0);
        wr(12'h320, 32'hFFFF_FFFF);
        rdc("inhibit_mask", 12'h320, inh_exp);
        wr(12'h320, 32'h0000_0004);
        repeat (5) begin retire = 1'b1; step(); end
        retire = 1'b0;
        rdc("minstret_inh", 12'hB02, 32'h0);
        wr(12'h320, 32'h0);
        repeat (3) begin retire = 1'b1; step(); end
        retire = 1'b0;
        rdc("minstret_cnt", 12'hB02, 32'd3);

        // HPM channel 3
        repeat (7) begin hpm_event = 4'b0001; step(); end
        hpm_event = '0;
        rdc("hpm3_lo", 12'hB03, hpm_exp);
        rdc("hpm3_hi", 12'hB83, 32'h0);

        // timer interrupt: cmp = mtime + 10 in the write cycle
        wr(12'h7C1, 32'h0);
        wr(12'h304, 32'h0000_0080);
        wr(12'h300, 32'h0000_0008);
        rdc("mtime_hi", 12'hFC1, 32'h0);
        acc(2'd0, 12'hFC0, 32'h0, m, il);
        acc(2'd1, 12'h7C0, m + 32'd11, r, il);
        repeat (9) step();
        chk("timer_early", {31'b0, irq_pending}, 32'h0);
        step();
        chk("timer_fire", {31'b0, irq_pending}, 32'h1);

        // trap and mret together, plus a mepc write that trap overrides
        trap_valid = 1'b1; mret = 1'b1;
        trap_pc = 32'h0000_2002; trap_cause = 32'h8000_0007;
        wr(12'h341, 32'h0000_5554);
        trap_valid = 1'b0; mret = 1'b0;
        chk("trapmret_mepc", mepc, 32'h0000_2000);
        chk("trapmret_irq", {31'b0, irq_pending}, 32'h0);
        rdc("trapmret_mstatus", 12'h300, 32'h0000_0080);
        rdc("trapmret_mcause", 12'h342, 32'h8000_0007);

        // asynchronous reset mid-cycle
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        chk("async_mtvec", mtvec, MTVEC_RST);
        chk("async_mepc", mepc, 32'h0);
        csr_req = 1'b1; csr_op = 2'd0; csr_addr = 12'h340;
        #1;
        chk("async_mscratch", csr_rdata, 32'h0);
        csr_req = 1'b0;
        step();
        resetn = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
